// File: rtl/pru_cmd_queue_if.sv
// pru_cmd_queue_if: CPU register bus plus PRU command/handshake bundle.
// slave is the queue side; master is the bus/PRU side.
interface pru_cmd_queue_if;
    logic        cpu_we;
    logic        cpu_re;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic [9:0]  pru_col;
    logic [8:0]  pru_row;
    logic [9:0]  pru_width;
    logic [8:0]  pru_height_radius;
    logic [1:0]  pru_color;
    logic [1:0]  pru_shape_select;
    logic        pru_subtract;
    logic        pru_start;
    logic        pru_busy;
    logic        pru_done;
    logic        pru_color_load;
    logic [31:0] pru_addr;
    logic [31:0] pru_data;

    modport slave (
        input  cpu_we, cpu_re, cpu_addr, cpu_wdata,
        input  pru_busy, pru_done,
        output cpu_rdata,
        output pru_col, pru_row, pru_width, pru_height_radius,
        output pru_color, pru_shape_select, pru_subtract,
        output pru_start, pru_color_load, pru_addr, pru_data
    );

    modport master (
        output cpu_we, cpu_re, cpu_addr, cpu_wdata,
        output pru_busy, pru_done,
        input  cpu_rdata,
        input  pru_col, pru_row, pru_width, pru_height_radius,
        input  pru_color, pru_shape_select, pru_subtract,
        input  pru_start, pru_color_load, pru_addr, pru_data
    );
endinterface

// File: rtl/pru_cmd_queue.sv
// pru_cmd_queue: buffers two-word draw commands and issues them to the
// PRU start/busy/done handshake; forwards palette writes; exposes status.
module pru_cmd_queue #(
    parameter int          DEPTH = 8,
    parameter logic [31:0] BASE  = 32'h4000_0100
) (
    input  logic           clk,
    input  logic           rst_n,
    pru_cmd_queue_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int EW = 43;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_REL  = 2'd2;

    logic [23:0]   r_w0;
    logic          r_commit;
    logic [EW-1:0] r_pend;
    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          r_perr;
    logic [1:0]    r_state;
    logic          r_start;
    logic [9:0]    r_col;
    logic [8:0]    r_row;
    logic [9:0]    r_width;
    logic [8:0]    r_hr;
    logic [1:0]    r_color;
    logic [1:0]    r_shape;
    logic          r_sub;
    logic          r_cload;
    logic [31:0]   r_paddr;
    logic [31:0]   r_pdata;
    logic [31:0]   r_rdata;

    logic          w_wr_w0;
    logic          w_wr_w1;
    logic          w_wr_st;
    logic          w_wr_pal;
    logic          w_rd_st;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_idle;
    logic [EW-1:0] w_head;
    logic [6:0]    w_cnt7;
    logic [31:0]   w_status;

    assign w_wr_w0  = bus.cpu_we && (bus.cpu_addr == BASE);
    assign w_wr_w1  = bus.cpu_we && (bus.cpu_addr == BASE + 32'h4);
    assign w_wr_st  = bus.cpu_we && (bus.cpu_addr == BASE + 32'h8);
    assign w_wr_pal = bus.cpu_we &&
                      ((bus.cpu_addr == BASE + 32'hC)  ||
                       (bus.cpu_addr == BASE + 32'h10) ||
                       (bus.cpu_addr == BASE + 32'h14) ||
                       (bus.cpu_addr == BASE + 32'h18));
    assign w_rd_st  = bus.cpu_addr == BASE + 32'h8;

    assign w_full  = r_count == CW'(DEPTH);
    assign w_empty = r_count == '0;
    assign w_idle  = r_state == S_IDLE;
    assign w_push  = r_commit && !w_full;
    assign w_pop   = w_idle && !w_empty &&
                     !bus.pru_busy && !bus.pru_done;
    assign w_head  = r_mem[r_rp];
    assign w_cnt7  = 7'(r_count);

    assign w_status = {18'd0, !w_idle, r_perr, r_ovf,
                       bus.pru_busy, w_empty, w_full,
                       1'b0, w_cnt7};

    // Stage W0 and latch a W1 write as a pending commit one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w0     <= '0;
            r_commit <= 1'b0;
            r_pend   <= '0;
        end else begin
            r_commit <= w_wr_w1;
            if (w_wr_w0)
                r_w0 <= bus.cpu_wdata[23:0];
            if (w_wr_w1)
                r_pend <= {r_w0, bus.cpu_wdata[18:0]};
        end
    end

    // FIFO storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wp] <= r_pend;
    end

    // FIFO pointers and occupancy; a push while full is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wp <= r_wp + AW'(1);
            if (w_pop)
                r_rp <= r_rp + AW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags; a new error wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf  <= 1'b0;
            r_perr <= 1'b0;
        end else begin
            if (r_commit && w_full)
                r_ovf <= 1'b1;
            else if (w_wr_st)
                r_ovf <= 1'b0;
            if (w_idle && (bus.pru_busy || bus.pru_done))
                r_perr <= 1'b1;
            else if (w_wr_st)
                r_perr <= 1'b0;
        end
    end

    // Dispatch FSM: pop, hold start until done, wait for done to drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_start <= 1'b0;
            r_col   <= '0;
            r_row   <= '0;
            r_width <= '0;
            r_hr    <= '0;
            r_color <= '0;
            r_shape <= '0;
            r_sub   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_sub   <= w_head[42];
                        r_shape <= w_head[41:40];
                        r_color <= w_head[39:38];
                        r_row   <= w_head[37:29];
                        r_col   <= w_head[28:19];
                        r_hr    <= w_head[18:10];
                        r_width <= w_head[9:0];
                        r_start <= 1'b1;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.pru_done) begin
                        r_start <= 1'b0;
                        r_state <= S_REL;
                    end
                end
                S_REL: begin
                    if (!bus.pru_done)
                        r_state <= S_IDLE;
                end
                default: begin
                    r_start <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Palette forwarding pulse and status readback register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cload <= 1'b0;
            r_paddr <= '0;
            r_pdata <= '0;
            r_rdata <= '0;
        end else begin
            r_cload <= w_wr_pal;
            if (w_wr_pal) begin
                r_paddr <= bus.cpu_addr;
                r_pdata <= bus.cpu_wdata;
            end
            if (bus.cpu_re)
                r_rdata <= w_rd_st ? w_status : 32'd0;
        end
    end

    assign bus.cpu_rdata         = r_rdata;
    assign bus.pru_col           = r_col;
    assign bus.pru_row           = r_row;
    assign bus.pru_width         = r_width;
    assign bus.pru_height_radius = r_hr;
    assign bus.pru_color         = r_color;
    assign bus.pru_shape_select  = r_shape;
    assign bus.pru_subtract      = r_sub;
    assign bus.pru_start         = r_start;
    assign bus.pru_color_load    = r_cload;
    assign bus.pru_addr          = r_paddr;
    assign bus.pru_data          = r_pdata;
endmodule

// File: tb/tb_pru_cmd_queue.sv
// tb_pru_cmd_queue: randomized bench for pru_cmd_queue with a
// queue-based command model and a behavioural PRU responder.
module tb_pru_cmd_queue;
    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h4000_0100;

    typedef struct packed {
        logic [9:0] col;
        logic [8:0] row;
        logic [9:0] width;
        logic [8:0] hr;
        logic [1:0] color;
        logic [1:0] shape;
        logic       sub;
    } cmd_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pru_cmd_queue_if bus();

    pru_cmd_queue #(.DEPTH(DEPTH), .BASE(BASE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic m_busy = 1'b0;
    logic m_done = 1'b0;
    logic s_done = 1'b0;
    bit   hold_mode = 1'b0;
    bit   rel = 1'b0;
    int   lat = 2;

    assign bus.pru_busy = m_busy;
    assign bus.pru_done = m_done | s_done;

    cmd_t        exp_q[$];
    logic [31:0] m_w0 = '0;
    bit          m_ovf = 1'b0;
    bit          m_perr = 1'b0;
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic cmd_t mk(input logic [31:0] w0,
                                input logic [31:0] w1);
        cmd_t c;
        c.col   = 10'(w0 % 1024);
        c.row   = 9'((w0 / 1024) % 512);
        c.color = 2'((w0 >> 19) % 4);
        c.shape = 2'((w0 >> 21) % 4);
        c.sub   = 1'((w0 >> 23) % 2);
        c.width = 10'(w1 % 1024);
        c.hr    = 9'((w1 / 1024) % 512);
        return c;
    endfunction

    function automatic logic [31:0] st_exp(input int cnt, input bit busy,
                                           input bit act);
        logic [31:0] v;
        v = 32'(cnt);
        if (cnt == DEPTH) v = v + 32'h100;
        if (cnt == 0)     v = v + 32'h200;
        if (busy)         v = v + 32'h400;
        if (m_ovf)        v = v + 32'h800;
        if (m_perr)       v = v + 32'h1000;
        if (act)          v = v + 32'h2000;
        return v;
    endfunction

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.cpu_we = 1'b1;
        bus.cpu_addr = a;
        bus.cpu_wdata = d;
        @(negedge clk);
        bus.cpu_we = 1'b0;
        bus.cpu_wdata = $urandom;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
        @(negedge clk);
        bus.cpu_re = 1'b1;
        bus.cpu_addr = a;
        @(negedge clk);
        bus.cpu_re = 1'b0;
        bus.cpu_addr = $urandom;
        v = bus.cpu_rdata;
    endtask

    task automatic st_chk(input string tag, input bit busy, input bit act);
        logic [31:0] v;
        bus_read(BASE + 32'h8, v);
        check(tag, v, st_exp(exp_q.size(), busy, act));
    endtask

    task automatic commit(input logic [31:0] w0, input logic [31:0] w1,
                          input bit wr0);
        if (wr0) begin
            bus_write(BASE, w0);
            m_w0 = w0;
        end
        bus_write(BASE + 32'h4, w1);
        if (exp_q.size() < DEPTH)
            exp_q.push_back(mk(m_w0, w1));
        else
            m_ovf = 1'b1;
    endtask

    task automatic wait_start(input string tag);
        for (int i = 0; i < 60 && !bus.pru_start; i++) @(negedge clk);
        check(tag, 32'(bus.pru_start), 32'd1);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 4000 &&
             (exp_q.size() != 0 || bus.pru_start || bus.pru_done); i++)
            @(negedge clk);
        repeat (4) @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // PRU responder: busy for lat cycles, optionally held, then done
    // until start drops.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.pru_start && !m_busy && !m_done) begin
                m_busy = 1'b1;
                for (int i = 0; i < lat && rst_n; i++) @(negedge clk);
                while (rst_n && hold_mode && !rel) @(negedge clk);
                rel = 1'b0;
                if (rst_n) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    for (int i = 0; i < 100 && bus.pru_start; i++)
                        @(negedge clk);
                end
                m_busy = 1'b0;
                m_done = 1'b0;
            end
        end
    end

    // Start monitor: each rising start must match the model queue head.
    initial begin
        logic prev;
        cmd_t cur;
        cmd_t act;
        prev = 1'b0;
        cur = '0;
        forever begin
            @(negedge clk);
            act.col   = bus.pru_col;
            act.row   = bus.pru_row;
            act.width = bus.pru_width;
            act.hr    = bus.pru_height_radius;
            act.color = bus.pru_color;
            act.shape = bus.pru_shape_select;
            act.sub   = bus.pru_subtract;
            if (bus.pru_start && !prev) begin
                check("start_has_cmd", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    check("col", 32'(act.col), 32'(cur.col));
                    check("row", 32'(act.row), 32'(cur.row));
                    check("width", 32'(act.width), 32'(cur.width));
                    check("hr", 32'(act.hr), 32'(cur.hr));
                    check("clr_shp_sub",
                          32'({act.color, act.shape, act.sub}),
                          32'({cur.color, cur.shape, cur.sub}));
                end
            end else if (bus.pru_start) begin
                check("stable", 32'(act ^ cur), 32'd0);
            end
            prev = bus.pru_start;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        logic [31:0] a;
        logic [31:0] d;
        int k;
        bus.cpu_we = 1'b0;
        bus.cpu_re = 1'b0;
        bus.cpu_addr = '0;
        bus.cpu_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_start", 32'(bus.pru_start), 32'd0);
        check("rst_fields", 32'(|{bus.pru_col, bus.pru_row, bus.pru_width,
              bus.pru_height_radius, bus.pru_color,
              bus.pru_shape_select, bus.pru_subtract}), 32'd0);
        check("rst_rdata", bus.cpu_rdata, 32'd0);
        check("rst_pal", 32'({bus.pru_color_load, |bus.pru_addr,
              |bus.pru_data}), 32'd0);
        rst_n = 1'b1;
        st_chk("st_reset", 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("rdata_hold", bus.cpu_rdata, st_exp(0, 1'b0, 1'b0));
        bus_read(BASE, v);
        check("rd_other", v, 32'd0);

        lat = 50;
        commit(32'h00A0_3C64, 32'h0000_7C20, 1'b1);
        check("rect_lat0", 32'(bus.pru_start), 32'd0);
        @(negedge clk);
        check("rect_lat1", 32'(bus.pru_start), 32'd0);
        @(negedge clk);
        check("rect_lat2", 32'(bus.pru_start), 32'd1);
        check("rect_col", 32'(bus.pru_col), 32'd100);
        check("rect_row", 32'(bus.pru_row), 32'd15);
        check("rect_w", 32'(bus.pru_width), 32'd32);
        check("rect_h", 32'(bus.pru_height_radius), 32'd31);
        for (int i = 0; i < 200 && !m_done; i++) @(negedge clk);
        check("rect_done", 32'(m_done), 32'd1);
        @(negedge clk);
        check("rect_fall", 32'(bus.pru_start), 32'd0);
        drain();
        st_chk("rect_empty", 1'b0, 1'b0);

        hold_mode = 1'b1;
        lat = 1;
        commit($urandom, $urandom, 1'b1);
        wait_start("burst_a");
        for (int i = 0; i < 8; i++)
            commit($urandom, $urandom, (i % 3) != 1);
        st_chk("burst_full", 1'b1, 1'b1);
        commit($urandom, $urandom, 1'b1);
        st_chk("burst_ovf", 1'b1, 1'b1);
        hold_mode = 1'b0;
        drain();
        st_chk("burst_drained", 1'b0, 1'b0);
        bus_write(BASE + 32'h8, $urandom);
        m_ovf = 1'b0;
        st_chk("ovf_clear", 1'b0, 1'b0);

        for (int dl = 0; dl < 6; dl++) begin
            hold_mode = 1'b1;
            lat = 1;
            commit($urandom, $urandom, 1'b1);
            wait_start("sim_a");
            for (int i = 0; i < 3; i++)
                commit($urandom, $urandom, 1'b1);
            st_chk("sim_cnt3", 1'b1, 1'b1);
            rel = 1'b1;
            repeat (dl) @(negedge clk);
            commit($urandom, $urandom, dl[0]);
            for (int i = 0; i < 60 && !(exp_q.size() == 3 && m_busy); i++)
                @(negedge clk);
            repeat (3) @(negedge clk);
            st_chk("sim_keep3", 1'b1, 1'b1);
            hold_mode = 1'b0;
            drain();
        end

        for (int i = 0; i < 4; i++) begin
            a = BASE + 32'hC + 32'(4 * i);
            d = (i == 1) ? 32'h1234_5678 : $urandom;
            bus_write(a, d);
            check("pal_load", 32'(bus.pru_color_load), 32'd1);
            check("pal_addr", bus.pru_addr, a);
            check("pal_data", bus.pru_data, d);
            @(negedge clk);
            check("pal_pulse", 32'(bus.pru_color_load), 32'd0);
        end
        bus_write(BASE + 32'h1C, $urandom);
        check("unmapped", 32'(bus.pru_color_load), 32'd0);
        st_chk("pal_fifo", 1'b0, 1'b0);

        @(negedge clk);
        s_done = 1'b1;
        m_perr = 1'b1;
        repeat (2) @(negedge clk);
        commit($urandom, $urandom, 1'b1);
        repeat (6) @(negedge clk);
        check("perr_stall", 32'(bus.pru_start), 32'd0);
        st_chk("perr_set", 1'b0, 1'b0);
        s_done = 1'b0;
        lat = 3;
        wait_start("perr_resume");
        drain();
        st_chk("perr_sticky", 1'b0, 1'b0);
        bus_write(BASE + 32'h8, 32'd0);
        m_perr = 1'b0;
        st_chk("perr_clear", 1'b0, 1'b0);

        hold_mode = 1'b1;
        lat = 2;
        commit($urandom, $urandom, 1'b1);
        wait_start("rst_a");
        for (int i = 0; i < 4; i++)
            commit($urandom, $urandom, 1'b1);
        st_chk("rst_q4", 1'b1, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async", 32'(bus.pru_start), 32'd0);
        check("rst_col", 32'(bus.pru_col), 32'd0);
        exp_q.delete();
        m_w0 = '0;
        hold_mode = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("rst_nostart", 32'(bus.pru_start), 32'd0);
        st_chk("rst_status", 1'b0, 1'b0);

        for (int b = 0; b < 8; b++) begin
            lat = $urandom_range(1, 6);
            k = $urandom_range(1, 8);
            for (int j = 0; j < k; j++) begin
                commit($urandom, $urandom,
                       (j == 0) || ($urandom_range(0, 3) != 0));
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            drain();
            st_chk("rand_idle", 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
